riscv_i32_trace_pack: RTL and testbench

Downstream consumer of the per-instruction trace event stream produced by the i32 trace stage. It compresses retired-instruction events into branch-trace packets: instruction counts, taken-branch targets and resynchronisation points. Packets are buffered in a small FIFO and drained as 32-bit words over a valid/ready interface to the debug/trace port. Trace never stalls the CPU; a full FIFO causes packet drops and a flagged resync.

---
 rtl/riscv_trace_pkg.sv | 33 +++
 rtl/riscv_trace_fifo_2w1r.sv | 51 +++++
 rtl/riscv_i32_trace_pack.sv | 150 +++++++++++++++
 tb/tb_riscv_i32_trace_pack.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared types for the i32 branch-trace packer: packet types, header layout
// and the per-instruction trace event record.
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        PKT_COUNT   = 2'b00,
        PKT_BRANCH  = 2'b01,
        PKT_SYNC    = 2'b10,
        PKT_OVFSYNC = 2'b11
    } pkt_type_t;

    localparam int unsigned HDR_TYPE_MSB        = 31;
    localparam int unsigned HDR_TYPE_LSB        = 30;
    localparam int unsigned HDR_COUNT_MAX_WIDTH = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        branch_taken;
        logic [31:0] branch_target;
    } trace_event_t;

    // Count is zero-extended by the caller, so bits above COUNT_WIDTH stay zero.
    function automatic logic [31:0] make_header(input pkt_type_t kind,
                                                input logic [HDR_COUNT_MAX_WIDTH-1:0] count);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_TYPE_MSB:HDR_TYPE_LSB]     = kind;
        hdr[HDR_COUNT_MAX_WIDTH-1:0]       = count;
        return hdr;
    endfunction

endpackage

// File: rtl/riscv_trace_fifo_2w1r.sv
// Generic 32-bit FIFO accepting 0, 1 or 2 words per cycle and popping at most one.
// The caller guarantees enough free space for every push.
module riscv_trace_fifo_2w1r #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               push_count,
    input  logic [31:0]              push_data0,
    input  logic [31:0]              push_data1,
    input  logic                     pop,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   level
);
    import riscv_trace_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_next_slot;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign wr_ptr_next_slot = wr_ptr + 1'b1;
    assign pop_ok           = pop && (level != '0);
    assign head             = (level != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_count != 2'd0) begin
            mem[wr_ptr] <= push_data0;
        end
        if (push_count == 2'd2) begin
            mem[wr_ptr_next_slot] <= push_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_count);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            level  <= level + LW'(push_count) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/riscv_i32_trace_pack.sv
// Compresses retired-instruction trace events into COUNT/BRANCH/SYNC/OVFSYNC
// packets and drains them as 32-bit words over valid/ready; never stalls the CPU.
module riscv_i32_trace_pack #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trace_enable,
    input  logic                     trace_valid,
    input  logic [31:0]              pc,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    output logic                     pkt_valid,
    output logic [31:0]              pkt_data,
    input  logic                     pkt_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow_pending,
    output logic                     overflow_seen
);
    import riscv_trace_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    trace_event_t           evt;
    logic                   enable_q;
    logic                   sync_pending;
    logic [COUNT_WIDTH-1:0] counter;

    logic                   sync_eff;
    logic [LW-1:0]          free;
    logic                   room1;
    logic                   room2;
    logic [31:0]            next_pc;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    logic [1:0]             push_count;
    logic [31:0]            push_data0;
    logic [31:0]            push_data1;
    logic                   pop;

    logic [COUNT_WIDTH-1:0] counter_next;
    logic                   sync_next;
    logic                   ovf_next;
    logic                   seen_next;

    assign evt.valid         = trace_enable & trace_valid;
    assign evt.pc            = pc;
    assign evt.branch_taken  = branch_taken;
    assign evt.branch_target = branch_target;

    // Fold the enable rising edge in combinationally so an event in that same
    // cycle already resynchronises.
    assign sync_eff = sync_pending | (trace_enable & ~enable_q);
    assign free     = LW'(DEPTH) - fifo_level;
    assign room1    = free >= LW'(1);
    assign room2    = free >= LW'(2);
    assign next_pc  = evt.branch_taken ? evt.branch_target : evt.pc + 32'd4;
    assign cnt_inc  = counter + 1'b1;

    always_comb begin
        push_count   = 2'd0;
        push_data0   = '0;
        push_data1   = '0;
        counter_next = trace_enable ? counter : '0;
        sync_next    = sync_eff;
        ovf_next     = overflow_pending;
        seen_next    = overflow_seen;

        if (evt.valid) begin
            if (overflow_pending) begin
                if (room2) begin
                    push_count   = 2'd2;
                    push_data0   = make_header(PKT_OVFSYNC, '0);
                    push_data1   = next_pc;
                    ovf_next     = 1'b0;
                    counter_next = '0;
                end
            end else if (sync_eff) begin
                if (room2) begin
                    push_count   = 2'd2;
                    push_data0   = make_header(PKT_SYNC, '0);
                    push_data1   = next_pc;
                    sync_next    = 1'b0;
                    counter_next = '0;
                end else begin
                    ovf_next     = 1'b1;
                    seen_next    = 1'b1;
                    counter_next = '0;
                end
            end else if (evt.branch_taken) begin
                if (room2) begin
                    push_count   = 2'd2;
                    push_data0   = make_header(PKT_BRANCH, HDR_COUNT_MAX_WIDTH'(cnt_inc));
                    push_data1   = evt.branch_target;
                    counter_next = '0;
                end else begin
                    ovf_next     = 1'b1;
                    seen_next    = 1'b1;
                    counter_next = '0;
                end
            end else if (cnt_inc == '1) begin
                if (room1) begin
                    push_count   = 2'd1;
                    push_data0   = make_header(PKT_COUNT, HDR_COUNT_MAX_WIDTH'(cnt_inc));
                    counter_next = '0;
                end else begin
                    ovf_next     = 1'b1;
                    seen_next    = 1'b1;
                    counter_next = '0;
                end
            end else begin
                counter_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q         <= 1'b0;
            sync_pending     <= 1'b1;
            counter          <= '0;
            overflow_pending <= 1'b0;
            overflow_seen    <= 1'b0;
        end else begin
            enable_q         <= trace_enable;
            sync_pending     <= sync_next;
            counter          <= counter_next;
            overflow_pending <= ovf_next;
            overflow_seen    <= seen_next;
        end
    end

    assign pkt_valid = fifo_level != '0;
    assign pop       = pkt_valid & pkt_ready;

    riscv_trace_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_count (push_count),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop        (pop),
        .head       (pkt_data),
        .level      (fifo_level)
    );

endmodule

// File: tb/tb_riscv_i32_trace_pack.sv
// Bench for riscv_i32_trace_pack: a default instance driven from a vector table
// and a DEPTH=4/COUNT_WIDTH=4 instance for overflow and counter-wrap sequences.
module tb_riscv_i32_trace_pack;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic        a_en = 0, a_v = 0, a_bt = 0, a_ready = 1;
    logic [31:0] a_pc = '0, a_tgt = '0, a_pdata;
    logic        a_pvalid, a_ovf, a_seen;
    logic [3:0]  a_level;

    logic        s_en = 0, s_v = 0, s_bt = 0, s_ready = 0;
    logic [31:0] s_pc = '0, s_tgt = '0, s_pdata;
    logic        s_pvalid, s_ovf, s_seen;
    logic [2:0]  s_level;

    logic [31:0] qa[$];
    logic [31:0] qs[$];

    riscv_i32_trace_pack dut_a (
        .clk(clk), .reset_n(reset_n), .trace_enable(a_en), .trace_valid(a_v),
        .pc(a_pc), .branch_taken(a_bt), .branch_target(a_tgt),
        .pkt_valid(a_pvalid), .pkt_data(a_pdata), .pkt_ready(a_ready),
        .fifo_level(a_level), .overflow_pending(a_ovf), .overflow_seen(a_seen)
    );

    riscv_i32_trace_pack #(.DEPTH(4), .COUNT_WIDTH(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .trace_enable(s_en), .trace_valid(s_v),
        .pc(s_pc), .branch_taken(s_bt), .branch_target(s_tgt),
        .pkt_valid(s_pvalid), .pkt_data(s_pdata), .pkt_ready(s_ready),
        .fifo_level(s_level), .overflow_pending(s_ovf), .overflow_seen(s_seen)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A word is popped at the next edge whenever valid & ready; compare it then.
    always @(negedge clk) begin
        if (reset_n && a_pvalid && a_ready) begin
            if (qa.size() == 0) cmp("a_unexpected_word", a_pdata, 32'hDEADDEAD);
            else cmp("a_word", a_pdata, qa.pop_front());
        end
        if (reset_n && s_pvalid && s_ready) begin
            if (qs.size() == 0) cmp("s_unexpected_word", s_pdata, 32'hDEADDEAD);
            else cmp("s_word", s_pdata, qs.pop_front());
        end
    end

    task automatic s_ev(input logic [31:0] p, input logic t, input logic [31:0] g);
        s_v = 1; s_pc = p; s_bt = t; s_tgt = g;
        tick();
        s_v = 0; s_bt = 0;
    endtask

    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] pc;
        logic        bt;
        logic [31:0] tgt;
        int unsigned nwords;
        logic [31:0] w0;
        logic [31:0] w1;
    } row_t;

    row_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 1, 32'h0000_1000, 0, 32'h0,          2, 32'h8000_0000, 32'h0000_1004};
        tbl[1]  = '{1, 1, 32'h0000_1004, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[2]  = '{1, 1, 32'h0000_1008, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[3]  = '{1, 1, 32'h0000_100C, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[4]  = '{1, 1, 32'h0000_2000, 1, 32'h0000_3000,  2, 32'h4000_0004, 32'h0000_3000};
        tbl[5]  = '{1, 0, 32'h0000_3000, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[6]  = '{1, 1, 32'h0000_3000, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[7]  = '{1, 1, 32'h0000_3004, 1, 32'h0000_0010,  2, 32'h4000_0002, 32'h0000_0010};
        tbl[8]  = '{0, 1, 32'h0000_0010, 0, 32'h0,          0, 32'h0,         32'h0};
        tbl[9]  = '{0, 1, 32'h0000_0014, 1, 32'h0000_0040,  0, 32'h0,         32'h0};
        tbl[10] = '{1, 1, 32'h0000_0020, 1, 32'h0000_0080,  2, 32'h8000_0000, 32'h0000_0080};
        tbl[11] = '{1, 1, 32'h0000_0080, 1, 32'h0000_0100,  2, 32'h4000_0001, 32'h0000_0100};
        tbl[12] = '{0, 0, 32'h0,         0, 32'h0,          0, 32'h0,         32'h0};
        tbl[13] = '{1, 1, 32'hFFFF_FFFC, 0, 32'h0,          2, 32'h8000_0000, 32'h0000_0000};
        tbl[14] = '{1, 1, 32'h0000_0000, 0, 32'h0,          0, 32'h0,         32'h0};

        reset_n = 0;
        repeat (3) tick();
        cmp("a_rst_valid", {31'b0, a_pvalid}, 0);
        cmp("a_rst_data",  a_pdata, 0);
        cmp("a_rst_level", {28'b0, a_level}, 0);
        cmp("a_rst_ovf",   {30'b0, a_ovf, a_seen}, 0);
        cmp("s_rst_valid", {31'b0, s_pvalid}, 0);
        cmp("s_rst_level", {29'b0, s_level}, 0);
        reset_n = 1;
        tick();

        // Default instance: table rows, one cycle each, consumer always ready.
        foreach (tbl[i]) begin
            a_en = tbl[i].en; a_v = tbl[i].v; a_pc = tbl[i].pc;
            a_bt = tbl[i].bt; a_tgt = tbl[i].tgt;
            if (tbl[i].nwords > 0) qa.push_back(tbl[i].w0);
            if (tbl[i].nwords > 1) qa.push_back(tbl[i].w1);
            tick();
        end
        a_v = 0; a_bt = 0;
        for (int i = 0; i < 40 && qa.size() != 0; i++) tick();
        cmp("a_drain_queue", qa.size(), 0);
        tick();
        cmp("a_end_level", {28'b0, a_level}, 0);
        cmp("a_end_ovf",   {30'b0, a_ovf, a_seen}, 0);

        // Small instance: fill, drop, pop, OVFSYNC recovery.
        s_en = 1;
        qs.push_back(32'h8000_0000); qs.push_back(32'h0000_1004);
        s_ev(32'h1000, 0, 0);
        cmp("s_sync_level", {29'b0, s_level}, 2);
        cmp("s_sync_ovf",   {31'b0, s_ovf}, 0);
        qs.push_back(32'h4000_0001); qs.push_back(32'h0000_4000);
        s_ev(32'h1004, 1, 32'h4000);
        cmp("s_full_level", {29'b0, s_level}, 4);
        s_ev(32'h4000, 1, 32'h4100);
        cmp("s_drop_ovf",   {30'b0, s_ovf, s_seen}, 3);
        cmp("s_drop_level", {29'b0, s_level}, 4);
        s_ev(32'h4100, 0, 0);
        cmp("s_discard_level", {29'b0, s_level}, 4);
        s_ready = 1;
        tick(); tick();
        s_ready = 0;
        cmp("s_pop2_level", {29'b0, s_level}, 2);
        qs.push_back(32'hC000_0000); qs.push_back(32'h0000_5004);
        s_ev(32'h5000, 0, 0);
        cmp("s_ovfsync_flags", {30'b0, s_ovf, s_seen}, 1);
        cmp("s_ovfsync_level", {29'b0, s_level}, 4);

        // Level DEPTH-1 with a simultaneous pop: the 2-word branch is still dropped.
        s_ready = 1;
        tick();
        cmp("s_pre_level", {29'b0, s_level}, 3);
        s_ev(32'h5004, 1, 32'h5100);
        cmp("s_pushpop_level", {29'b0, s_level}, 2);
        cmp("s_pushpop_ovf",   {31'b0, s_ovf}, 1);
        for (int i = 0; i < 20 && (qs.size() != 0 || s_level != 0); i++) tick();
        cmp("s_drain1_queue", qs.size(), 0);

        // Counter saturation at 2^4-1.
        qs.push_back(32'hC000_0000); qs.push_back(32'h0000_6004);
        s_ev(32'h6000, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 14) qs.push_back(32'h0000_000F);
            s_ev(32'h6004 + 32'(4 * i), 0, 0);
        end
        qs.push_back(32'h4000_0002); qs.push_back(32'h0000_8000);
        s_ev(32'h6100, 1, 32'h8000);
        for (int i = 0; i < 20 && (qs.size() != 0 || s_level != 0); i++) tick();
        cmp("s_drain2_queue", qs.size(), 0);
        cmp("s_cnt_flags", {30'b0, s_ovf, s_seen}, 1);

        // Reset while words are still queued.
        s_ready = 0;
        s_ev(32'h8000, 1, 32'h8100);
        cmp("s_prerst_level", {29'b0, s_level}, 2);
        reset_n = 0;
        tick();
        reset_n = 1;
        cmp("s_midrst_level", {29'b0, s_level}, 0);
        cmp("s_midrst_valid", {31'b0, s_pvalid}, 0);
        cmp("s_midrst_data",  s_pdata, 0);
        cmp("s_midrst_flags", {30'b0, s_ovf, s_seen}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
